serial_subtractor: RTL and testbench

Bit-serial, multi-cycle subtractor and the inverse companion of the team's ripple-carry adder. It computes x - y - bin one bit per clock, LSB first, using a single full-subtractor cell and a registered borrow. It trades latency for area in datapaths that are not timing-critical. A start/busy/done handshake lets a controller FSM issue one operation at a time.

---
 rtl/serial_subtractor.sv | 135 +++++++++++++
 tb/tb_serial_subtractor.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: x - y - bin, one bit per clock, LSB first, start/busy/done handshake.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q, r_q;
  logic             br_q;
  logic [CW-1:0]    cnt_q;
  logic             d_c, br_nxt_c, last_c;
  logic             busy_nxt, done_nxt;

`ifdef SERIAL_SUB_OVF_EN
  logic             xm_q, ym_q;
`endif

  // Full-subtractor cell on the current LSBs
  always_comb begin
    d_c      = a_q[0] ^ b_q[0] ^ br_q;
    br_nxt_c = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    last_c   = (cnt_q == CW'(WIDTH - 1));
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_SHIFT;
      S_SHIFT: if (last_c) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode, registered below
  always_comb begin
    busy_nxt = (state_nxt != S_IDLE);
    done_nxt = (state == S_DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy <= 1'b0;
      done <= 1'b0;
      diff <= '0;
      bout <= 1'b0;
    end else begin
      busy <= busy_nxt;
      done <= done_nxt;
      if (state == S_DONE) begin
        diff <= r_q;
        bout <= br_q;
      end
    end
  end

  // Operand shift registers, result accumulator, borrow and bit counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q   <= '0;
      b_q   <= '0;
      r_q   <= '0;
      br_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_q   <= x;
            b_q   <= y;
            br_q  <= bin;
            r_q   <= '0;
            cnt_q <= '0;
          end
        end
        S_SHIFT: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          r_q   <= {d_c, r_q[WIDTH-1:1]};
          br_q  <= br_nxt_c;
          cnt_q <= last_c ? cnt_q : cnt_q + CW'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  // Operand sign bits are held so overflow can be judged against the final MSB
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      xm_q <= 1'b0;
      ym_q <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      if (state == S_IDLE && start) begin
        xm_q <= x[WIDTH-1];
        ym_q <= y[WIDTH-1];
      end
      if (state == S_DONE) ovf <= (xm_q ^ ym_q) & (xm_q ^ r_q[WIDTH-1]);
    end
  end
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: vector table, handshake corner cases, random ops.
// Define SERIAL_SUB_OVF_EN to also check the overflow output.
module tb_serial_subtractor;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic [W-1:0] x, y;
  logic         bin;
  logic         busy, done, bout;
  logic [W-1:0] diff;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .x(x), .y(y), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .bout(bout)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] x, y;
    logic       bin;
    logic [7:0] ed;
    logic       eb;
    logic       eo;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain modulo and signed arithmetic
  function automatic void model(input logic [7:0] xi, input logic [7:0] yi, input logic bi,
                                output logic [7:0] d, output logic bo, output logic ov);
    int sx, sy, sr;
    d  = 8'(int'(xi) - int'(yi) - int'(bi));
    bo = (int'(xi) < int'(yi) + int'(bi));
    sx = int'($signed(xi));
    sy = int'($signed(yi));
    sr = sx - sy - int'(bi);
    ov = (sr > 127) || (sr < -128);
  endfunction

  // One operation; optionally inject an ignored start with other operands after inj cycles
  task automatic run_op(input logic [7:0] xi, input logic [7:0] yi, input logic bi, input int inj,
                        output logic [7:0] d, output logic bo, output logic ov);
    int g = 0;
    int n = 0;
    int bcnt = 0;
    while (busy && g < 50) begin
      tick();
      g++;
    end
    if (busy) check("idle_wait_timeout", 32'(busy), 32'd0);
    x = xi; y = yi; bin = bi; start = 1'b1;
    tick();
    start = 1'b0;
    x = 8'($urandom); y = 8'($urandom); bin = 1'($urandom);
    if (busy) bcnt++;
    while (n < 40 && !done) begin
      if (n == inj) begin
        start = 1'b1; x = 8'hAA; y = 8'h01;
      end else begin
        start = 1'b0;
      end
      tick();
      n++;
      if (busy) bcnt++;
    end
    start = 1'b0;
    check("latency", 32'(n), 32'(W + 1));
    check("busy_cycles", 32'(bcnt), 32'(W + 1));
    d  = diff;
    bo = bout;
`ifdef SERIAL_SUB_OVF_EN
    ov = ovf;
`else
    ov = 1'b0;
`endif
    tick();
    check("done_width", 32'(done), 32'd0);
    check("diff_hold", 32'(diff), 32'(d));
  endtask

  initial begin
    vec_t       tbl[8];
    logic [7:0] d, md;
    logic       bo, ov, mb, mo;
    int         g;

    tbl[0] = '{8'h50, 8'h30, 1'b0, 8'h20, 1'b0, 1'b0};
    tbl[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
    tbl[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
    tbl[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    tbl[4] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
    tbl[5] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
    tbl[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    tbl[7] = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0};

    reset_n = 1'b0; start = 1'b0; x = '0; y = '0; bin = 1'b0;
    repeat (3) tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_bout", 32'(bout), 32'd0);
    reset_n = 1'b1;
    tick();

    foreach (tbl[i]) begin
      run_op(tbl[i].x, tbl[i].y, tbl[i].bin, -1, d, bo, ov);
      check($sformatf("tbl%0d_diff", i), 32'(d), 32'(tbl[i].ed));
      check($sformatf("tbl%0d_bout", i), 32'(bo), 32'(tbl[i].eb));
`ifdef SERIAL_SUB_OVF_EN
      check($sformatf("tbl%0d_ovf", i), 32'(ov), 32'(tbl[i].eo));
`endif
    end

    // Start while busy is ignored, including its operands
    run_op(8'h50, 8'h30, 1'b0, 3, d, bo, ov);
    check("ign_diff", 32'(d), 32'h20);
    check("ign_bout", 32'(bo), 32'd0);
    repeat (3) tick();
    check("ign_no_second_op", 32'(busy), 32'd0);

    // Asynchronous reset in the middle of an operation
    x = 8'h50; y = 8'h30; bin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    #2 reset_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_diff", 32'(diff), 32'd0);
    check("arst_bout", 32'(bout), 32'd0);
    tick();
    reset_n = 1'b1;
    g = 0;
    repeat (15) begin
      tick();
      if (done || busy) g++;
    end
    check("arst_no_done", 32'(g), 32'd0);
    run_op(8'h05, 8'h03, 1'b0, -1, d, bo, ov);
    check("arst_after_diff", 32'(d), 32'h02);

    // Randomized back-to-back operations against the arithmetic model
    for (int i = 0; i < 1000; i++) begin
      logic [7:0] rx, ry;
      logic       rb;
      rx = 8'($urandom);
      ry = 8'($urandom);
      rb = 1'($urandom);
      model(rx, ry, rb, md, mb, mo);
      run_op(rx, ry, rb, -1, d, bo, ov);
      check("rnd_diff", 32'(d), 32'(md));
      check("rnd_bout", 32'(bo), 32'(mb));
`ifdef SERIAL_SUB_OVF_EN
      check("rnd_ovf", 32'(ov), 32'(mo));
`endif
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
